// File: rtl/mc_pkg.sv
// Shared microcontroller definitions: opcodes, sequencer states and fault codes.
package mc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    LOAD,
    DECODE,
    ISSUE,
    EXEC,
    HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_ILLEGAL  = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_RESERVED = 2'b11
  } fault_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction-memory port, execution-unit handshake and status.
// master: the sequencer (drives imem_addr, ir, unit_start, pc, halted, fault).
// slave:  memory / execution units / observer (drives imem_data, unit_done, pc_inc).
interface instr_sequencer_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned N_UNITS = 8
) ();

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ir;
  logic [N_UNITS-1:0] unit_start;
  logic [N_UNITS-1:0] unit_done;
  logic               pc_inc;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic [1:0]         fault;

  modport master (
    output imem_addr, ir, unit_start, pc, halted, fault,
    input  imem_data, unit_done, pc_inc
  );

  modport slave (
    input  imem_addr, ir, unit_start, pc, halted, fault,
    output imem_data, unit_done, pc_inc
  );

endinterface

// File: rtl/instr_sequencer_watchdog.sv
// EXEC-phase watchdog counter.
// Ports: clk, reset (sync, active-high), clear (zero the count), enable (count this cycle),
// expired (high during the TIMEOUT-th enabled cycle since the last clear).
module exec_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q;
  logic            at_last;

  assign at_last = (count_q == Last);
  // Combinational so the fault can be taken on the edge that ends the last cycle.
  assign expired = enable && at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !at_last) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/dispatch controller. Fetches from a synchronous instruction memory at pc,
// decodes the opcode, pulses unit_start for the selected unit and waits for its done.
// Ports: clk, reset (sync, active-high), bus (instr_sequencer_if.master):
//   imem_addr/imem_data memory port, ir latched instruction, unit_start/unit_done handshake,
//   pc_inc increment request, pc, halted, fault (valid while halted).
module instr_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned N_UNITS = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  instr_sequencer_if.master bus
);

  seq_state_t         state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [N_UNITS-1:0] unit_start_q;
  logic               halted_q;
  fault_t             fault_q;

  logic [3:0]         opcode;
  logic [N_UNITS-1:0] sel_onehot;
  logic               unit_legal;
  logic               done_hit;
  logic               wd_expired;

  assign opcode = ir_q[INSTR_W-1 -: 4];
  // Opcode k+1 selects unit k; opcode 0 shifts the bit out entirely.
  assign sel_onehot = N_UNITS'(1) << (opcode - 4'd1);
  assign unit_legal = (opcode != OP_NOP) && (opcode != OP_HALT) && (32'(opcode) <= N_UNITS);
  // ir is held through EXEC, so the selection can be re-derived from it.
  assign done_hit = |(bus.unit_done & sel_onehot);

  exec_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ISSUE),
    .enable  (state_q == EXEC),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      unit_start_q <= '0;
      halted_q     <= 1'b0;
      fault_q      <= FAULT_NONE;
    end else begin
      unit_start_q <= '0;
      case (state_q)
        FETCH: state_q <= LOAD;
        LOAD: begin
          ir_q    <= bus.imem_data;
          state_q <= DECODE;
        end
        DECODE: begin
          if (opcode == OP_NOP) begin
            pc_q    <= pc_q + 1'b1;
            state_q <= FETCH;
          end else if (opcode == OP_HALT) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= FAULT_NONE;
          end else if (unit_legal) begin
            unit_start_q <= sel_onehot;
            state_q      <= ISSUE;
          end else begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= FAULT_ILLEGAL;
          end
        end
        ISSUE: state_q <= EXEC;
        EXEC: begin
          if (bus.pc_inc) begin
            pc_q <= pc_q + 1'b1;
          end
          // A done in the final watchdog cycle still completes normally.
          if (done_hit) begin
            state_q <= FETCH;
          end else if (wd_expired) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= FAULT_TIMEOUT;
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.unit_start = unit_start_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_bad;

  logic [15:0] mem [256];

  instr_sequencer_if #(.ADDR_W(8), .INSTR_W(16), .N_UNITS(8)) bus ();

  instr_sequencer #(
    .ADDR_W  (8),
    .INSTR_W (16),
    .N_UNITS (8),
    .TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid one cycle after the address.
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  // Returns at the negedge of the first FETCH cycle after reset.
  task automatic do_reset();
    reset = 1'b1;
    bus.pc_inc = 1'b0;
    bus.unit_done = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the negedge of the ISSUE cycle, or flags a timeout.
  task automatic wait_start(input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (bus.unit_start != '0) found = 1'b1;
    end
    check("wait_start", {31'd0, found}, 32'd1);
  endtask

  logic [7:0] seen;

  initial begin
    n_checks = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.pc_inc = 1'b0;
    bus.unit_done = '0;
    clear_mem();

    // NOP then HALT; pc_inc held high the whole time must be ignored outside EXEC.
    mem[1] = 16'hF000;
    do_reset();
    bus.pc_inc = 1'b1;
    seen = '0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      seen |= bus.unit_start;
      if (k == 0) begin
        check("rst_pc", bus.pc, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_ir", bus.ir, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_fault", bus.fault, 0);
      end
      if (k == 3) check("nop_pc", bus.pc, 1);
      if (k == 6) begin
        check("halt_halted", bus.halted, 1);
        check("halt_fault", bus.fault, 0);
      end
    end
    bus.pc_inc = 1'b0;
    check("halt_pc_frozen", bus.pc, 1);
    check("halt_no_start", seen, 0);

    // MOVI: pc_inc once in EXEC2, done in EXEC3.
    clear_mem();
    mem[0] = 16'h1234;
    mem[1] = 16'hF000;
    do_reset();
    repeat (3) @(negedge clk);
    check("movi_start", bus.unit_start, 8'h01);
    check("movi_ir", bus.ir, 16'h1234);
    @(negedge clk);
    check("movi_start_1cyc", bus.unit_start, 0);
    @(negedge clk);
    bus.pc_inc = 1'b1;
    @(negedge clk);
    bus.pc_inc = 1'b0;
    bus.unit_done = 8'h01;
    check("movi_pc", bus.pc, 1);
    check("movi_ir_held", bus.ir, 16'h1234);
    @(negedge clk);
    bus.unit_done = '0;
    check("movi_next_addr", bus.imem_addr, 1);
    check("movi_not_halted", bus.halted, 0);
    repeat (3) @(negedge clk);
    check("movi_then_halt", bus.halted, 1);

    // Illegal opcode.
    clear_mem();
    mem[0] = 16'hA000;
    do_reset();
    repeat (3) @(negedge clk);
    check("ill_halted", bus.halted, 1);
    check("ill_fault", bus.fault, 2'b01);
    check("ill_pc", bus.pc, 0);
    check("ill_no_start", bus.unit_start, 0);

    // Watchdog: EXEC cycles are k=4..67.
    clear_mem();
    mem[0] = 16'h1000;
    do_reset();
    repeat (67) @(negedge clk);
    check("wd_not_yet", bus.halted, 0);
    @(negedge clk);
    check("wd_halted", bus.halted, 1);
    check("wd_fault", bus.fault, 2'b10);
    check("wd_pc", bus.pc, 0);

    // Done in the 64th EXEC cycle wins over the timeout.
    do_reset();
    repeat (67) @(negedge clk);
    bus.unit_done = 8'h01;
    @(negedge clk);
    bus.unit_done = '0;
    check("wd_done_halted", bus.halted, 0);
    check("wd_done_fault", bus.fault, 0);
    check("wd_done_addr", bus.imem_addr, 0);

    // Wrap from 0xFF; done in ISSUE and a stray done are ignored; inc+done together.
    clear_mem();
    mem[255] = 16'h2000;
    do_reset();
    wait_start(900);
    check("wrap_start", bus.unit_start, 8'h02);
    check("wrap_pc_ff", bus.pc, 8'hFF);
    bus.unit_done = 8'h02;
    @(negedge clk);
    bus.unit_done = 8'h01;
    @(negedge clk);
    bus.unit_done = 8'h02;
    bus.pc_inc = 1'b1;
    @(negedge clk);
    bus.unit_done = '0;
    bus.pc_inc = 1'b0;
    check("wrap_pc", bus.pc, 0);
    check("wrap_addr", bus.imem_addr, 0);
    check("wrap_not_halted", bus.halted, 0);

    // Reset in EXEC with pc=5.
    clear_mem();
    mem[5] = 16'h1000;
    do_reset();
    wait_start(40);
    check("rx_pc5", bus.pc, 5);
    @(negedge clk);
    reset = 1'b1;
    bus.pc_inc = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.pc_inc = 1'b0;
    check("rx_pc", bus.pc, 0);
    check("rx_addr", bus.imem_addr, 0);
    check("rx_start", bus.unit_start, 0);
    check("rx_halted", bus.halted, 0);
    check("rx_ir", bus.ir, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/dispatch controller for the microcontroller. It fetches instruction words from instruction memory at the current PC and decodes the opcode. It issues a one-cycle start pulse to the matching execution unit (MOVI, ALU ops, …) and waits for that unit's `Done`. It owns the PC, which units advance through their `PC_Increment` outputs.

## Interface
- `ADDR_W`, 8: PC / instruction-memory address width.
- `INSTR_W`, 16: instruction width; opcode is bits `[INSTR_W-1:INSTR_W-4]`.
- `N_UNITS`, 8: number of execution units; unit k is selected by opcode k+1.
- `TIMEOUT`, 64: max EXEC cycles before watchdog fault; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_addr`  out  ADDR_W  always equals `pc`.
- `imem_data`  in  INSTR_W  instruction word; synchronous memory, valid one cycle after `imem_addr`.
- `ir`  out  INSTR_W  latched instruction; operand fields are consumed by the units and held stable from ISSUE through EXEC.
- `unit_start`  out  N_UNITS  one-hot start pulse to the selected unit.
- `unit_done`  in  N_UNITS  per-unit `Done`.
- `pc_inc`  in  1  OR of all units' `PC_Increment`.
- `pc`  out  ADDR_W  program counter.
- `halted`  out  1  sequencer stopped; cleared only by reset.
- `fault`  out  2  00 none, 01 illegal opcode, 10 watchdog timeout, 11 reserved; valid when `halted`.

## Operation
- States: FETCH → LOAD → DECODE → ISSUE → EXEC → FETCH; terminal HALT.
- FETCH: address `pc` is on `imem_addr`.
- LOAD: `ir <= imem_data`.
- DECODE classifies the opcode:
  - 0x0 NOP: `pc <= pc+1`, next state FETCH, no unit started.
  - 0xF HALT: next state HALT, `fault=00`.
  - 1..N_UNITS: next state ISSUE.
  - Any other opcode: next state HALT, `fault=01`.
- ISSUE: `unit_start[opcode-1]=1` for exactly one cycle. The watchdog is cleared to 0.
- EXEC:
  - Each cycle with `pc_inc=1` performs `pc <= pc+1`; multiple pulses give multiple increments.
  - `unit_done[sel]=1` → FETCH.
  - Done bits of non-selected units are ignored.
  - Watchdog counts EXEC cycles. Reaching TIMEOUT without done → HALT, `fault=10`.
- `pc_inc` is ignored outside EXEC. `unit_done` is ignored outside EXEC, including the ISSUE cycle.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 → 0x00 for ADDR_W=8. No carry or flag.
- HALT: all `unit_start` = 0, `pc` frozen; remains there until reset.
- Reset, at any point including mid-EXEC, on the same edge:
  - state=FETCH, `pc=0`, `ir=0`, `unit_start=0`, `halted=0`, `fault=00`, watchdog=0.
  - A unit still busy is reset by the same `reset` line.

## Timing
- `unit_start`, `halted` and `fault` are registered (Moore outputs). `imem_addr` is combinational from `pc`.
- Instruction fetch-to-start latency is 3 cycles: FETCH edge 0, LOAD, DECODE, then `unit_start` high in cycle 3.
- A NOP costs 3 cycles.
- For a unit instruction:
  - Minimum cost is 5 cycles, when done arrives in the first EXEC cycle.
  - Total cycles = 4 + (cycles in EXEC).
- If `pc_inc` and `unit_done` are both high in the same EXEC cycle, the increment is applied and the transition to FETCH occurs. The next fetch uses the updated `pc`.
- Timeout: fault is taken on the edge ending the TIMEOUT-th EXEC cycle. A done in that same cycle wins: no fault.

## Structure
- Shared package `mc_pkg`:
  - opcode constants `OP_NOP=4'h0`, `OP_HALT=4'hF`, `OP_MOVI=4'h1`;
  - `seq_state_t` enum (FETCH, LOAD, DECODE, ISSUE, EXEC, HALT);
  - fault codes.
- One sub-module: `exec_watchdog`, a counter with clear/enable and a `expired` output, parameterised by TIMEOUT.

## Test plan
- Reset, then memory {0x0000, 0xF000} → FETCH at pc 0, NOP gives pc=1, HALT gives `halted=1`, `fault=00`, `pc=1`, no `unit_start` ever.
- Memory[0]=0x1234 (MOVI), model unit pulses `pc_inc` once and done 3 cycles after start → `unit_start=0x01` exactly one cycle at cycle 3, `ir=0x1234` stable, `pc=1`, fetch of addr 1 follows.
- Opcode 0xA with N_UNITS=8 → halted, `fault=01`, `pc` unchanged at 0.
- Unit never returns done, TIMEOUT=64 → `halted`, `fault=10` after exactly 64 EXEC cycles. Repeat with done in cycle 64 → no fault.
- pc=0xFF and the unit pulses `pc_inc` → pc=0x00. Also:
  - `pc_inc` and done in the same cycle → next fetch at the incremented pc;
  - a stray `unit_done` from another unit → ignored.
- Assert reset during EXEC with pc=0x05 → next cycle state FETCH, `pc=0`, `unit_start=0`, `halted=0`, `ir=0`.
